// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared FSM encoding, counter-width helper and default parameters
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK_HI = 2'd1,
        ST_HELD     = 2'd2,
        ST_CHECK_LO = 2'd3
    } db_state_e;

    localparam int DEF_NUM_BTN         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_BTN_ACTIVE_LOW  = 0;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 5000000;

    // Bits needed to hold a count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-flop synchronizer, debounce FSM, optional auto-repeat (BUTTON_CONDITIONER_AUTOREPEAT_EN)
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          btn_sync;
    db_state_e     state;
    db_state_e     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          press_nxt;
    logic          rel_nxt;
    logic          repeat_fire;
    logic          cnt_done;

    assign btn_sync = sync_q[1];
    // The counter enters CHECK at 1, so reaching DEBOUNCE_CYCLES-1 means this edge is the DEBOUNCE_CYCLES-th stable sample.
    assign cnt_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Two-flop synchronizer bringing the raw button into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    // State register, qualification counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // Next state: any sample disagreeing with the candidate level restarts the window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_nxt = ST_CHECK_HI;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_CHECK_HI: begin
                if (!btn_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_done) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (!btn_sync) begin
                    state_nxt = ST_CHECK_LO;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_CHECK_LO: begin
                if (btn_sync) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt_done) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: level follows the accepted side, pulses mark accepting transitions.
    always_comb begin
        level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_CHECK_LO);
        press_nxt = ((state == ST_CHECK_HI) && (state_nxt == ST_HELD)) || repeat_fire;
        rel_nxt   = (state == ST_CHECK_LO) && (state_nxt == ST_IDLE);
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW       = cnt_width(HOLD_MAX);

    logic [HW-1:0] hold_cnt;
    logic          repeating;
    logic          stay_held;

    assign stay_held   = (state == ST_HELD) && (state_nxt == ST_HELD);
    assign repeat_fire = stay_held &&
                         (repeating ? (hold_cnt == HW'(REPEAT_CYCLES - 1))
                                    : (hold_cnt == HW'(HOLD_CYCLES - 1)));

    // Hold timer: first interval is HOLD_CYCLES, later ones REPEAT_CYCLES; cleared whenever HELD is left.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (!stay_held) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (repeat_fire) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    localparam int cfg_unused = HOLD_CYCLES + REPEAT_CYCLES;
    assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchronize/debounce/edge-pulse top; auto-repeat via BUTTON_CONDITIONER_AUTOREPEAT_EN
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_rel
);

    logic [NUM_BTN-1:0] btn_in;

    assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .btn_in(btn_in[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_rel[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench against a sample-window reference model
module tb_button_conditioner;

    localparam int NB   = 2;
    localparam int D    = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_rel;

    always #5 clock = ~clock;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (0),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_rel  (btn_rel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the FSM sees raw delayed by two samples; a level flips once the
    // last D samples it has seen all disagree with the current level.
    bit            m_s1 [NB];
    bit            m_s2 [NB];
    bit            m_hist [NB][$];
    bit            m_level [NB];
    int            m_hold [NB];
    bit            m_broke [NB];
    logic [NB-1:0] e_level, e_press, e_rel;

    function automatic void model_reset();
        for (int ch = 0; ch < NB; ch++) begin
            m_s1[ch] = 0; m_s2[ch] = 0; m_level[ch] = 0;
            m_hold[ch] = 0; m_broke[ch] = 0;
            m_hist[ch].delete();
        end
        e_level = '0; e_press = '0; e_rel = '0;
    endfunction

    function automatic void model_edge(input logic [NB-1:0] raw);
        for (int ch = 0; ch < NB; ch++) begin
            bit in_b;
            bit all_diff;
            in_b = m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
            m_hist[ch].push_back(in_b);
            if (m_hist[ch].size() > D) void'(m_hist[ch].pop_front());
            e_press[ch] = 1'b0;
            e_rel[ch]   = 1'b0;
            all_diff = (m_hist[ch].size() == D);
            for (int i = 0; i < m_hist[ch].size(); i++)
                if (m_hist[ch][i] == m_level[ch]) all_diff = 0;
            if (all_diff) begin
                m_level[ch] = ~m_level[ch];
                if (m_level[ch]) begin
                    e_press[ch] = 1'b1;
                    m_hold[ch]  = 0;
                    m_broke[ch] = 0;
                end else begin
                    e_rel[ch] = 1'b1;
                end
            end else if (m_level[ch]) begin
                if (!in_b) begin
                    m_broke[ch] = 1;
                end else if (m_broke[ch]) begin
                    m_broke[ch] = 0;
                    m_hold[ch]  = 0;
                end else begin
                    m_hold[ch]++;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    if (m_hold[ch] == HOLD || (m_hold[ch] > HOLD && (m_hold[ch] - HOLD) % REP == 0))
                        e_press[ch] = 1'b1;
`endif
                end
            end
            e_level[ch] = m_level[ch];
        end
    endfunction

    int cyc = 0;
    int press_log [NB][$];
    int rel_cnt [NB];
    int lvl_hi [NB];

    function automatic void clear_logs();
        for (int ch = 0; ch < NB; ch++) begin
            press_log[ch].delete();
            rel_cnt[ch] = 0;
            lvl_hi[ch]  = 0;
        end
    endfunction

    function automatic int first_press(input int ch);
        return (press_log[ch].size() > 0) ? press_log[ch][0] : -1000;
    endfunction

    task automatic tick(input logic [NB-1:0] raw);
        btn_raw = raw;
        @(posedge clock);
        if (reset) model_edge(raw);
        else model_reset();
        cyc++;
        @(negedge clock);
        check("level", btn_level, e_level);
        check("press", btn_press, e_press);
        check("rel", btn_rel, e_rel);
        check("press_rel_excl", btn_press & btn_rel, 0);
        for (int ch = 0; ch < NB; ch++) begin
            if (btn_press[ch] === 1'b1) press_log[ch].push_back(cyc);
            if (btn_rel[ch] === 1'b1) rel_cnt[ch]++;
            if (btn_level[ch] === 1'b1) lvl_hi[ch]++;
        end
    endtask

    // Asynchronous reset pulse between clock edges, called from the negedge phase.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_level", btn_level, 0);
        check("async_rst_press", btn_press, 0);
        check("async_rst_rel", btn_rel, 0);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int rise;
        int p;
        logic [NB-1:0] r;

        reset   = 1'b0;
        btn_raw = 2'b11;
        model_reset();
        @(negedge clock);
        for (int i = 0; i < 4; i++) tick(2'b11);
        check("rst_hold_level", btn_level, 0);

        // Reset release with both buttons already held.
        reset = 1'b1;
        clear_logs();
        base = cyc;
        for (int i = 0; i < 12; i++) tick(2'b11);
        check("rst_press0_lat", first_press(0) - (base + 1), 5);
        check("rst_press1_lat", first_press(1) - (base + 1), 5);
        check("rst_level_after", btn_level, 2'b11);
        for (int i = 0; i < 10; i++) tick(2'b00);

        // Clean press/release on channel 1.
        clear_logs();
        for (int i = 0; i < 10; i++) tick(2'b10);
        for (int i = 0; i < 10; i++) tick(2'b00);
        check("clean_press1_cnt", press_log[1].size(), 1);
        check("clean_rel1_cnt", rel_cnt[1], 1);
        check("clean_level1_cycles", lvl_hi[1], 10);
        check("clean_ch0_quiet", press_log[0].size(), 0);

        // Bounce on channel 0, then a steady press.
        clear_logs();
        tick(2'b01); tick(2'b00); tick(2'b01); tick(2'b01); tick(2'b00);
        tick(2'b01);
        rise = cyc;
        for (int i = 0; i < 11; i++) tick(2'b01);
        check("bounce_press_cnt", press_log[0].size(), 1);
        check("bounce_press_lat", first_press(0) - rise, 5);
        for (int i = 0; i < 10; i++) tick(2'b00);

        // Three-cycle glitch must be rejected.
        clear_logs();
        for (int i = 0; i < 3; i++) tick(2'b01);
        for (int i = 0; i < 10; i++) tick(2'b00);
        check("glitch_press_cnt", press_log[0].size(), 0);
        check("glitch_level_cycles", lvl_hi[0], 0);
        check("glitch_rel_cnt", rel_cnt[0], 0);

        // Asynchronous reset while channel 0 is held.
        for (int i = 0; i < 8; i++) tick(2'b01);
        check("hold_before_rst", btn_level, 2'b01);
        btn_raw = 2'b00;
        async_reset_pulse();
        clear_logs();
        for (int i = 0; i < 10; i++) tick(2'b00);
        check("post_rst_rel_cnt", rel_cnt[0], 0);
        check("post_rst_level_cycles", lvl_hi[0], 0);

        // Long hold: auto-repeat pulses only when the feature is built.
        clear_logs();
        base = cyc;
        for (int i = 0; i < 48; i++) tick(2'b01);
        for (int i = 0; i < 10; i++) tick(2'b00);
        p = first_press(0);
        check("hold_first_lat", p - (base + 1), 5);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        check("hold_press_cnt", press_log[0].size(), 5);
        if (press_log[0].size() == 5) begin
            check("repeat_1", press_log[0][1] - p, 16);
            check("repeat_2", press_log[0][2] - p, 24);
            check("repeat_3", press_log[0][3] - p, 32);
            check("repeat_4", press_log[0][4] - p, 40);
        end
`else
        check("hold_press_cnt", press_log[0].size(), 1);
`endif
        check("hold_rel_cnt", rel_cnt[0], 1);

        // Randomized bounce with varying flip rates and occasional async resets.
        r = 2'b00;
        for (int blk = 0; blk < 15; blk++) begin
            int pct;
            pct = (blk % 3 == 0) ? 40 : ((blk % 3 == 1) ? 15 : 4);
            for (int i = 0; i < 100; i++) begin
                for (int ch = 0; ch < NB; ch++)
                    if ($urandom_range(0, 99) < pct) r[ch] = ~r[ch];
                tick(r);
                if ($urandom_range(0, 299) == 0) async_reset_pulse();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
